// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Copies word_count 32-bit words from src_addr to dst_addr in ascending
//   order, one word per two cycles (a READ cycle, then a WRITE cycle).
//   Requests that are misaligned or that run past MEM_WORDS are rejected
//   with a one-cycle error pulse and no memory access.
//
// Ports
//   clk         in   1   clock, all state updates on posedge
//   rst_n       in   1   synchronous active-low reset
//   start       in   1   one-cycle copy request, honoured only in IDLE
//   src_addr    in   32  byte address of first source word
//   dst_addr    in   32  byte address of first destination word
//   word_count  in   16  number of words to copy
//   busy        out  1   high in every state except IDLE
//   done        out  1   one-cycle pulse on successful completion
//   error       out  1   one-cycle pulse on a rejected request
//   MemRead     out  1   memory read enable
//   MemWrite    out  1   memory write enable (commits on posedge)
//   address     out  32  word-aligned byte address to memory
//   WriteData   out  32  data to memory
//   ReadData    in   32  combinational read data from memory
module mem_copy_engine #(
  parameter int MEM_WORDS = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WRITE  = 3'd2,
    S_FINISH = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  // Range limit widened so (addr>>2)+count can never wrap.
  localparam logic [33:0] MEM_LIMIT = 34'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] hold_q, hold_d;
  logic [15:0] count_q, count_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] address_q, address_d;
  logic [31:0] wdata_q, wdata_d;

  // A request is legal when both addresses are word aligned and both
  // word ranges end at or below MEM_WORDS.
  function automatic logic req_ok(input logic [31:0] s, input logic [31:0] d,
                                  input logic [15:0] n);
    logic [33:0] s_end;
    logic [33:0] d_end;
    s_end = {4'd0, s[31:2]} + {18'd0, n};
    d_end = {4'd0, d[31:2]} + {18'd0, n};
    return (s[1:0] == 2'd0) && (d[1:0] == 2'd0) &&
           (s_end <= MEM_LIMIT) && (d_end <= MEM_LIMIT);
  endfunction

  // Next-state, pointer, count and holding-register logic.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          count_d = word_count;
          if (!req_ok(src_addr, dst_addr, word_count)) begin
            state_d = S_FAULT;
          end else if (word_count == 16'd0) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        hold_d  = ReadData;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        src_d   = src_q + 32'd4;
        dst_d   = dst_q + 32'd4;
        count_d = count_q - 16'd1;
        // Decision uses the count before this word's decrement.
        if (count_q > 16'd1) begin
          state_d = S_READ;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_FAULT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line
  // up with the state they describe.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FINISH);
    error_d     = (state_d == S_FAULT);
    mem_read_d  = (state_d == S_READ);
    mem_write_d = (state_d == S_WRITE);
    case (state_d)
      S_READ:  begin address_d = src_d; wdata_d = 32'd0;  end
      S_WRITE: begin address_d = dst_d; wdata_d = hold_d; end
      default: begin address_d = 32'd0; wdata_d = 32'd0;  end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      src_q       <= 32'd0;
      dst_q       <= 32'd0;
      hold_q      <= 32'd0;
      count_q     <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      address_q   <= 32'd0;
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      hold_q      <= hold_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign MemRead   = mem_read_q;
  assign MemWrite  = mem_write_q;
  assign address   = address_q;
  assign WriteData = wdata_q;

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter MEM_WORDS, default 8192, word capacity of the attached data memory, used for range checking.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 src_addr  input  32  byte address of the first source word.
REQ-006 dst_addr  input  32  byte address of the first destination word.
REQ-007 word_count  input  16  number of 32-bit words to copy.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse on successful completion.
REQ-010 error  output  1  one-cycle pulse on a rejected request; no memory access is performed.
REQ-011 MemRead  output  1  memory read enable.
REQ-012 MemWrite  output  1  memory write enable; memory commits on the posedge while high.
REQ-013 address  output  32  byte address to memory; bits [1:0] are always 0 when MemRead or MemWrite is high.
REQ-014 WriteData  output  32  data to memory.
REQ-015 ReadData  input  32  combinational read data from memory, valid in the same cycle MemRead is high.

Function
REQ-016 FSM states: IDLE, READ, WRITE, FINISH, FAULT.
REQ-017 On start in IDLE, src_addr, dst_addr and word_count are latched; later changes to these inputs have no effect on the running copy.
REQ-018 Request check at start: if src_addr[1:0]!=0, dst_addr[1:0]!=0, or (addr>>2)+word_count > MEM_WORDS for either address (computed at 33+ bits, no wrap), go to FAULT.
REQ-019 A valid request with word_count=0 goes to FINISH with no memory access.
REQ-020 Otherwise go to READ.
REQ-021 READ: MemRead=1, address=current src pointer; ReadData is captured into a 32-bit holding register on the posedge; next state is WRITE.
REQ-022 WRITE: MemWrite=1, address=current dst pointer, WriteData=holding register; on the posedge both pointers advance by 4 and remaining count decrements by 1.
REQ-023 Transition out of WRITE: next state is READ if remaining count > 1 before the decrement, otherwise FINISH.
REQ-024 FINISH: done=1 for exactly one cycle, then IDLE.
REQ-025 FAULT: error=1 for exactly one cycle, then IDLE.
REQ-026 MemRead and MemWrite are never high in the same cycle.
REQ-027 Both MemRead and MemWrite are 0 in IDLE, FINISH and FAULT.
REQ-028 In IDLE, FINISH and FAULT, address and WriteData are 0.
REQ-029 Latency: start accepted on edge E0 gives done high in cycle 2N+1 after E0, for N words; N=0 or a faulted request gives the pulse in cycle 1.
REQ-030 Throughput: one word per 2 cycles; the engine has no stall input.
REQ-031 Copy order is ascending; overlapping ranges are copied word by word in ascending order, with no overlap detection.
REQ-032 start while busy is ignored and not queued.
REQ-033 start in the same cycle as a FINISH or FAULT pulse is ignored; it is accepted only in IDLE.
REQ-034 The largest legal request, word_count=MEM_WORDS from address 0, completes without pointer overflow.

Reset
REQ-035 When rst_n=0 at a posedge, the state goes to IDLE and busy, done, error, MemRead, MemWrite, address and WriteData are all 0 from the next cycle.
REQ-036 Reset mid-copy aborts immediately: no further memory write occurs after the reset edge, and words already written remain written.
REQ-037 The holding register, pointers and count reset to 0.
REQ-038 Reset has priority over start.

Verification
REQ-039 Preload mem[250..253]=A,B,C,D; start with src=0x3E8, dst=0x1000, count=4 -> mem[0x400..0x403]=A,B,C,D; done pulses in cycle 9; busy high for cycles 1-9.
REQ-040 start with count=0 -> done in cycle 1, no MemRead or MemWrite ever high, busy high for 1 cycle.
REQ-041 start with src=0x3EA -> error in cycle 1, no memory access; same result with dst=0x7FFC, count=2, MEM_WORDS=8192.
REQ-042 Overlap: mem[0..3]=1,2,3,4; src=0, dst=4, count=3 -> mem[1..3]=1,1,1.
REQ-043 rst_n=0 during the second WRITE of a 4-word copy -> only the first 1-2 destination words change; outputs are 0 the next cycle; a new start then completes normally.
REQ-044 Pulse start again at cycle 3 of a running copy -> it is ignored; only one done pulse occurs; the inputs were changed mid-copy and the original latched values are still used.
